// File: rtl/piano_tone_gen.sv
// Multi-key square-wave tone generator: synchronises keys and octave, picks the
// highest pressed key and toggles the speaker every effective half-period.
module piano_tone_gen #(
    parameter int NUM_KEYS    = 12,
    parameter int CNT_W       = 19,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key,
    input  logic [1:0]          octave_sel,
    input  logic                mute,
    output logic                speaker,
    output logic                note_valid,
    output logic [3:0]          note_idx
);

    // Octave-4 half-periods in 50 MHz cycles, one per semitone.
    function automatic logic [CNT_W-1:0] base_half(input logic [3:0] idx);
        logic [CNT_W-1:0] h;
        case (idx)
            4'd0:    h = CNT_W'(95557);
            4'd1:    h = CNT_W'(90194);
            4'd2:    h = CNT_W'(85132);
            4'd3:    h = CNT_W'(80353);
            4'd4:    h = CNT_W'(75844);
            4'd5:    h = CNT_W'(71588);
            4'd6:    h = CNT_W'(67570);
            4'd7:    h = CNT_W'(63777);
            4'd8:    h = CNT_W'(60198);
            4'd9:    h = CNT_W'(56819);
            4'd10:   h = CNT_W'(53630);
            4'd11:   h = CNT_W'(50620);
            default: h = '0;
        endcase
        return h;
    endfunction

    logic [NUM_KEYS-1:0] key_sync_q [SYNC_STAGES];
    logic [NUM_KEYS-1:0] key_sync_d [SYNC_STAGES];
    logic [1:0]          oct_sync_q [SYNC_STAGES];
    logic [1:0]          oct_sync_d [SYNC_STAGES];

    logic             note_valid_q, note_valid_d;
    logic [3:0]       note_idx_q, note_idx_d;
    logic [CNT_W-1:0] tc_q, tc_d;
    logic [1:0]       oct_q, oct_d;
    logic             mute_q, mute_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             spk_q, spk_d;

    logic [NUM_KEYS-1:0] key_s;
    logic [1:0]          oct_s;
    logic                sel_valid;
    logic [3:0]          sel_idx;
    logic [CNT_W-1:0]    sel_half;
    logic [CNT_W-1:0]    sel_eff;
    logic [CNT_W-1:0]    sel_tc;
    logic                note_change;

    always_comb begin
        key_sync_d[0] = key;
        oct_sync_d[0] = octave_sel;
        for (int s = 1; s < SYNC_STAGES; s++) begin
            key_sync_d[s] = key_sync_q[s-1];
            oct_sync_d[s] = oct_sync_q[s-1];
        end
    end

    assign key_s = key_sync_q[SYNC_STAGES-1];
    assign oct_s = oct_sync_q[SYNC_STAGES-1];

    // Top-note priority: the last set bit found in ascending order wins.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 4'd0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (key_s[i]) begin
                sel_valid = 1'b1;
                sel_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        sel_half = base_half(sel_idx);
        case (oct_s)
            2'd0:    sel_eff = sel_half << 1;
            2'd1:    sel_eff = sel_half;
            2'd2:    sel_eff = sel_half >> 1;
            default: sel_eff = sel_half >> 2;
        endcase
        sel_tc = sel_valid ? (sel_eff - CNT_W'(1)) : '0;
    end

    assign note_change = (sel_idx != note_idx_q) || (oct_s != oct_q);

    always_comb begin
        note_valid_d = sel_valid;
        note_idx_d   = sel_idx;
        tc_d         = sel_tc;
        oct_d        = oct_s;
        mute_d       = mute;
    end

    // Priority: release > mute > (re)start > note change > count.
    // A restart is the first edge with a note and no mute; it behaves like a
    // fresh note so the low phase after unmute is a full half-period.
    always_comb begin
        cnt_d = cnt_q;
        spk_d = spk_q;
        if (!sel_valid) begin
            cnt_d = '0;
            spk_d = 1'b0;
        end else if (mute) begin
            cnt_d = '0;
            spk_d = 1'b0;
        end else if (!note_valid_q || mute_q) begin
            cnt_d = '0;
            spk_d = 1'b0;
        end else if (note_change) begin
            cnt_d = '0;
        end else if (cnt_q == tc_q) begin
            cnt_d = '0;
            spk_d = ~spk_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                key_sync_q[s] <= '0;
                oct_sync_q[s] <= '0;
            end
            note_valid_q <= 1'b0;
            note_idx_q   <= 4'd0;
            tc_q         <= '0;
            oct_q        <= 2'd0;
            mute_q       <= 1'b0;
            cnt_q        <= '0;
            spk_q        <= 1'b0;
        end else begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                key_sync_q[s] <= key_sync_d[s];
                oct_sync_q[s] <= oct_sync_d[s];
            end
            note_valid_q <= note_valid_d;
            note_idx_q   <= note_idx_d;
            tc_q         <= tc_d;
            oct_q        <= oct_d;
            mute_q       <= mute_d;
            cnt_q        <= cnt_d;
            spk_q        <= spk_d;
        end
    end

    assign speaker    = spk_q;
    assign note_valid = note_valid_q;
    assign note_idx   = note_idx_q;

endmodule

// File: tb/tb_piano_tone_gen.sv
// Directed bench for piano_tone_gen: latency, half-period timing, priority,
// glitch-free note change, mute, release and asynchronous reset.
module tb_piano_tone_gen;

    localparam int E11_O6 = 12655;   // 50620 >> 2
    localparam int E10_O6 = 13407;   // 53630 >> 2

    logic        clk;
    logic        rst_n;
    logic [11:0] key;
    logic [1:0]  octave_sel;
    logic        mute;
    logic        speaker;
    logic        note_valid;
    logic [3:0]  note_idx;

    int checks = 0;
    int errors = 0;

    piano_tone_gen dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key        (key),
        .octave_sel (octave_sel),
        .mute       (mute),
        .speaker    (speaker),
        .note_valid (note_valid),
        .note_idx   (note_idx)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #(20 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_toggle(input logic from_lvl, input int limit, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (speaker === from_lvl && n < limit);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        key = '0;
        octave_sel = 2'd0;
        mute = 1'b0;
        repeat (3) tick();
        checks++;
        if (speaker !== 1'b0) begin errors++; $display("FAIL reset_speaker: got %b want 0", speaker); end
        checks++;
        if (note_valid !== 1'b0) begin errors++; $display("FAIL reset_note_valid: got %b want 0", note_valid); end
        checks++;
        if (note_idx !== 4'd0) begin errors++; $display("FAIL reset_note_idx: got %0d want 0", note_idx); end
        rst_n = 1'b1;
        repeat (2) tick();
        checks++;
        if (note_valid !== 1'b0 || speaker !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: valid=%b spk=%b want 0 0", note_valid, speaker);
        end
    endtask

    task automatic test_start_and_latency;
        int n;
        key = '0;
        key[11] = 1'b1;
        octave_sel = 2'd3;
        tick();
        checks++;
        if (note_valid !== 1'b0) begin errors++; $display("FAIL latency_edge1: valid=%b want 0", note_valid); end
        tick();
        checks++;
        if (note_valid !== 1'b0) begin errors++; $display("FAIL latency_edge2: valid=%b want 0", note_valid); end
        tick();
        checks++;
        if (note_valid !== 1'b1 || note_idx !== 4'd11 || speaker !== 1'b0) begin
            errors++; $display("FAIL latency_edge3: valid=%b idx=%0d spk=%b want 1 11 0", note_valid, note_idx, speaker);
        end
        wait_toggle(1'b0, E11_O6 + 10, n);
        checks++;
        if (n != E11_O6 || speaker !== 1'b1) begin
            errors++; $display("FAIL first_rise: after %0d cycles spk=%b want %0d cycles spk 1", n, speaker, E11_O6);
        end
        repeat (5000) tick();
        checks++;
        if (speaker !== 1'b1) begin errors++; $display("FAIL high_mid: spk=%b want 1", speaker); end
    endtask

    task automatic test_note_change;
        int n;
        key = '0;
        key[10] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            if (speaker !== 1'b1) begin errors++; $display("FAIL change_glitch: spk=%b want 1", speaker); end
        end while (note_idx !== 4'd10 && n < 10);
        checks++;
        if (n != 3) begin errors++; $display("FAIL change_latency: got %0d edges want 3", n); end
        checks++;
        if (dut.tc_q !== 19'd13406 || dut.cnt_q !== 19'd0) begin
            errors++; $display("FAIL change_load: tc=%0d cnt=%0d want 13406 0", dut.tc_q, dut.cnt_q);
        end
        wait_toggle(1'b1, E10_O6 + 10, n);
        checks++;
        if (n != E10_O6 || speaker !== 1'b0) begin
            errors++; $display("FAIL change_hold: %0d cycles spk=%b want %0d cycles spk 0", n, speaker, E10_O6);
        end
        wait_toggle(1'b0, E10_O6 + 10, n);
        checks++;
        if (n != E10_O6 || speaker !== 1'b1) begin
            errors++; $display("FAIL low_phase: %0d cycles spk=%b want %0d cycles spk 1", n, speaker, E10_O6);
        end
    endtask

    task automatic test_mute;
        int n;
        int bad;
        repeat (100) tick();
        mute = 1'b1;
        tick();
        checks++;
        if (speaker !== 1'b0 || note_valid !== 1'b1 || note_idx !== 4'd10) begin
            errors++; $display("FAIL mute_on: spk=%b valid=%b idx=%0d want 0 1 10", speaker, note_valid, note_idx);
        end
        bad = 0;
        repeat (999) begin
            tick();
            if (speaker !== 1'b0 || note_valid !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL mute_hold: %0d bad cycles want 0", bad); end
        mute = 1'b0;
        tick();
        checks++;
        if (speaker !== 1'b0 || dut.cnt_q !== 19'd0) begin
            errors++; $display("FAIL unmute_restart: spk=%b cnt=%0d want 0 0", speaker, dut.cnt_q);
        end
        wait_toggle(1'b0, E10_O6 + 10, n);
        checks++;
        if (n != E10_O6 || speaker !== 1'b1) begin
            errors++; $display("FAIL unmute_rise: %0d cycles spk=%b want %0d cycles spk 1", n, speaker, E10_O6);
        end
    endtask

    task automatic test_release;
        repeat (50) tick();
        key = '0;
        tick();
        tick();
        checks++;
        if (speaker !== 1'b1 || note_valid !== 1'b1) begin
            errors++; $display("FAIL release_pre: spk=%b valid=%b want 1 1", speaker, note_valid);
        end
        tick();
        checks++;
        if (speaker !== 1'b0 || note_valid !== 1'b0 || note_idx !== 4'd0 || dut.cnt_q !== 19'd0) begin
            errors++; $display("FAIL release_edge: spk=%b valid=%b idx=%0d cnt=%0d want 0 0 0 0",
                               speaker, note_valid, note_idx, dut.cnt_q);
        end
    endtask

    task automatic test_priority_tc;
        key = '0;
        key[3] = 1'b1;
        key[9] = 1'b1;
        octave_sel = 2'd1;
        repeat (3) tick();
        checks++;
        if (note_valid !== 1'b1 || note_idx !== 4'd9 || dut.tc_q !== 19'd56818) begin
            errors++; $display("FAIL prio_3_9: valid=%b idx=%0d tc=%0d want 1 9 56818", note_valid, note_idx, dut.tc_q);
        end
        key[9] = 1'b0;
        repeat (3) tick();
        checks++;
        if (note_idx !== 4'd3 || dut.tc_q !== 19'd80352 || dut.cnt_q !== 19'd0) begin
            errors++; $display("FAIL drop_to_3: idx=%0d tc=%0d cnt=%0d want 3 80352 0", note_idx, dut.tc_q, dut.cnt_q);
        end
        key = '0;
        key[9] = 1'b1;
        octave_sel = 2'd3;
        repeat (3) tick();
        checks++;
        if (note_idx !== 4'd9 || dut.tc_q !== 19'd14203) begin
            errors++; $display("FAIL key9_oct6: idx=%0d tc=%0d want 9 14203", note_idx, dut.tc_q);
        end
        key = '0;
        key[0] = 1'b1;
        octave_sel = 2'd0;
        repeat (3) tick();
        checks++;
        if (note_idx !== 4'd0 || note_valid !== 1'b1 || dut.tc_q !== 19'd191113 || dut.cnt_q !== 19'd0) begin
            errors++; $display("FAIL key0_oct3: idx=%0d valid=%b tc=%0d cnt=%0d want 0 1 191113 0",
                               note_idx, note_valid, dut.tc_q, dut.cnt_q);
        end
        repeat (5) tick();
        checks++;
        if (dut.cnt_q !== 19'd5 || speaker !== 1'b0) begin
            errors++; $display("FAIL key0_count: cnt=%0d spk=%b want 5 0", dut.cnt_q, speaker);
        end
        octave_sel = 2'd2;
        repeat (3) tick();
        checks++;
        if (note_idx !== 4'd0 || dut.tc_q !== 19'd47777 || dut.cnt_q !== 19'd0) begin
            errors++; $display("FAIL octave_change: idx=%0d tc=%0d cnt=%0d want 0 47777 0", note_idx, dut.tc_q, dut.cnt_q);
        end
    endtask

    task automatic test_async_reset;
        key = '0;
        key[11] = 1'b1;
        octave_sel = 2'd3;
        repeat (3) tick();
        repeat (100) tick();
        checks++;
        if (note_idx !== 4'd11 || dut.cnt_q !== 19'd100) begin
            errors++; $display("FAIL pre_reset: idx=%0d cnt=%0d want 11 100", note_idx, dut.cnt_q);
        end
        #4;
        rst_n = 1'b0;
        #1;
        checks++;
        if (speaker !== 1'b0 || note_valid !== 1'b0 || note_idx !== 4'd0 || dut.cnt_q !== 19'd0) begin
            errors++; $display("FAIL async_reset: spk=%b valid=%b idx=%0d cnt=%0d want 0 0 0 0",
                               speaker, note_valid, note_idx, dut.cnt_q);
        end
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (note_valid !== 1'b0) begin errors++; $display("FAIL restart_edge2: valid=%b want 0", note_valid); end
        tick();
        checks++;
        if (note_valid !== 1'b1 || note_idx !== 4'd11 || speaker !== 1'b0) begin
            errors++; $display("FAIL restart_edge3: valid=%b idx=%0d spk=%b want 1 11 0", note_valid, note_idx, speaker);
        end
    endtask

    initial begin
        test_reset();
        test_start_and_latency();
        test_note_change();
        test_mute();
        test_release();
        test_priority_tc();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/piano_tone_gen.md
Name: piano_tone_gen

Overview:
Parametrised multi-key square-wave tone generator for the piano project, replacing the per-note fixed-divider blocks. It samples a key vector and an octave select, picks one sounding note by top-note priority, and toggles a single speaker output at that note's half-period. It sits between the keyboard/button inputs and the speaker pin, and reports the active note for the display logic.

Parameters:
NUM_KEYS, 12, number of key inputs (1..12); key i maps to semitone i (0=C ... 11=B).
CNT_W, 19, half-period counter width; must hold 191113.
SYNC_STAGES, 2, flip-flop stages on key and octave inputs (>=2).

Ports:
clk  in  1  system clock, 50 MHz.
rst_n  in  1  asynchronous active-low reset.
key  in  NUM_KEYS  raw key levels, 1 = pressed; asynchronous to clk.
octave_sel  in  2  0=octave 3, 1=octave 4, 2=octave 5, 3=octave 6; asynchronous.
mute  in  1  synchronous to clk; 1 = silence output.
speaker  out  1  square-wave tone.
note_valid  out  1  1 = at least one synchronised key pressed.
note_idx  out  4  semitone index of sounding note; 0 when note_valid=0.

Behaviour:
- Reset (rst_n=0, asynchronous): speaker=0, note_valid=0, note_idx=0, counter=0, terminal register=0, all sync flops=0. Takes effect immediately, including mid-tone.
- Input sync: key and octave_sel each pass through SYNC_STAGES flops. No debounce.
- Selection: highest set index of the synchronised key vector wins. note_valid and note_idx are registered one cycle after the last sync stage, giving 3 rising edges from a stable input to output with the default SYNC_STAGES.
- Base half-periods H (cycles) for octave 4 at 50 MHz, indexed 0..11: 95557, 90194, 85132, 80353, 75844, 71588, 67570, 63777, 60198, 56819, 53630, 50620.
- Effective half-period E: octave_sel 0 gives H<<1; 1 gives H; 2 gives H>>1 (floor); 3 gives H>>2 (floor). Terminal count TC = E-1 is registered together with note_idx.
- Tone: counter counts 0..TC. When counter==TC, the counter returns to 0 and speaker inverts. Each half-period lasts exactly E cycles. No off-by-one is allowed.
- Note start (note_valid 0 to 1): counter=0, speaker=0. The first speaker rise occurs E cycles after note_valid rises.
- Note change (note_idx or synchronised octave changes while note_valid=1): in the same cycle the new TC loads and the counter clears to 0. Speaker holds its current level, so no glitch pulse occurs. The next toggle comes E_new cycles later.
- Release (note_valid 1 to 0): speaker=0 and counter=0 on the same edge that note_valid falls.
- Mute: while mute=1, speaker is forced to 0 and the counter is held at 0 from the next edge. note_valid and note_idx continue to track the keys. When mute is released with a note active, the tone restarts as a note start (speaker=0, counter=0).
- Precedence: rst_n > release > mute > note change > normal count.
- Key bits at index >= NUM_KEYS do not exist. note_idx never exceeds NUM_KEYS-1.

Test Plan:
1. Reset, then key[3]=1, octave_sel=1 -> note_valid=1 and note_idx=3 after 3 edges; first speaker rise 80353 cycles later; period 160706 cycles; duty exactly 50%.
2. key[3] and key[9] both held -> note_idx=9; half-period 56819; releasing key[9] -> note_idx=3, counter clears, half-period 80353.
3. key[9] with octave_sel=3 -> half-period 14204. key[0] with octave_sel=0 -> half-period 191114, with no counter overflow at CNT_W=19.
4. Change key[3] to key[9] while speaker=1 and the counter is mid-count -> speaker stays 1 for exactly 56819 cycles after note_idx updates, then toggles.
5. mute=1 for 1000 cycles during a tone -> speaker=0 on the next edge with note_valid still 1; mute=0 -> speaker=0 for E cycles, then rises. Releasing all keys -> speaker=0 and note_idx=0 on the same edge.
6. Pulse rst_n=0 for 3 ns between clock edges mid-tone -> all outputs 0 immediately; after rst_n returns to 1 with the key still held, the note restarts with the 3-edge latency.
